// File: rtl/despread_pkg.sv
// despread_pkg: shared state type, default widths and 32-bit clamp bounds for the despreader
package despread_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;
  localparam int SAMPLE_WIDTH_D = 32;
  localparam int CODE_WIDTH_D = 16;
  localparam int SYMBOL_LEN_D = 64;
  localparam int ACC_WIDTH_D = 56;
  localparam int OUT_SHIFT_D = 6;
  localparam int CNT_WIDTH = $clog2(SYMBOL_LEN_D);
  localparam longint SAT_HI = 64'sh7FFFFFFF;
  localparam longint SAT_LO = -64'sh80000000;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/despread_mac.sv
// despread_mac: two-stage multiply-accumulate with first-chip load, flush and done
module despread_mac #(
  parameter int SW = 32,
  parameter int CW = 16,
  parameter int AW = 56
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic                 first,
  input  logic                 last,
  input  logic                 flush,
  input  logic signed [SW-1:0] sample,
  input  logic signed [CW-1:0] code,
  output logic                 done,
  output logic signed [AW-1:0] acc_nxt
);
  localparam int PW = SW + CW;
  logic signed [PW-1:0] p;
  logic p_vld, p_first, p_last;
  logic signed [AW-1:0] acc;
  assign acc_nxt = p_first ? AW'(p) : acc + AW'(p);
  assign done = p_vld & p_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p <= '0;
      p_vld <= 1'b0;
      p_first <= 1'b0;
      p_last <= 1'b0;
      acc <= '0;
    end else begin
      p_vld <= in_vld;
      if (in_vld) begin
        p <= PW'(sample) * PW'(code);
        p_first <= first;
        p_last <= last;
      end
      if (p_vld & !flush) acc <= acc_nxt;
    end
endmodule

// File: rtl/signal_despread.sv
// signal_despread: code-multiply, per-symbol integrate and decide; SIGNAL_DESPREAD_SAT_EN clamps corr_out
module signal_despread
  import despread_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_D,
  parameter int CODE_WIDTH = CODE_WIDTH_D,
  parameter int SYMBOL_LEN = SYMBOL_LEN_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sync_start,
  input  logic                           sync_stop,
  input  logic signed [SAMPLE_WIDTH-1:0] Signal_Recv,
  input  logic                           Signal_Recv_valid,
  input  logic signed [CODE_WIDTH-1:0]   MSEQ_code,
  input  logic                           MSEQ_code_valid,
  output logic signed [31:0]             corr_out,
  output logic                           corr_valid,
  output logic                           bit_out,
  output logic                           corr_sat,
  output logic                           sample_miss,
  output logic                           busy
);
  localparam int CW = cnt_width(SYMBOL_LEN);
  state_t state;
  logic [CW-1:0] cnt;
  logic act, start, stop, accept, miss, done;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  assign act = state == ACCUM;
  assign busy = act;
  assign stop = act & sync_stop;
  assign start = sync_start & !sync_stop;
  assign accept = act & !sync_stop & Signal_Recv_valid & MSEQ_code_valid;
  assign miss = act & !sync_stop & Signal_Recv_valid & !MSEQ_code_valid;
  despread_mac #(.SW(SAMPLE_WIDTH), .CW(CODE_WIDTH), .AW(ACC_WIDTH)) u_mac (
    .clk(clk),
    .rst(rst),
    .in_vld(accept),
    .first(sync_start | (cnt == '0)),
    .last(!sync_start & (cnt == CW'(SYMBOL_LEN - 1))),
    .flush(act & (sync_start | sync_stop)),
    .sample(Signal_Recv),
    .code(MSEQ_code),
    .done(done),
    .acc_nxt(acc_nxt)
  );
`ifdef SIGNAL_DESPREAD_SAT_EN
  logic signed [ACC_WIDTH-1:0] sh;
  logic hi, lo;
  assign sh = acc_nxt >>> OUT_SHIFT;
  assign hi = 64'(sh) > SAT_HI;
  assign lo = 64'(sh) < SAT_LO;
`else
  assign corr_sat = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sample_miss <= 1'b0;
      corr_valid <= 1'b0;
      corr_out <= '0;
      bit_out <= 1'b0;
`ifdef SIGNAL_DESPREAD_SAT_EN
      corr_sat <= 1'b0;
`endif
    end else begin
      state <= stop ? IDLE : start ? ACCUM : state;
      cnt <= (stop | start) ? CW'(accept) : cnt + CW'(accept);
      sample_miss <= (start ? 1'b0 : sample_miss) | miss;
      // a symbol completed just before a restart still reports; a stop drops it
      corr_valid <= done & !stop;
      if (done & !stop) begin
        bit_out <= !acc_nxt[ACC_WIDTH-1];
`ifdef SIGNAL_DESPREAD_SAT_EN
        corr_out <= hi ? 32'(SAT_HI) : lo ? 32'(SAT_LO) : sh[31:0];
        corr_sat <= hi | lo;
`else
        corr_out <= 32'(acc_nxt >>> OUT_SHIFT);
`endif
      end
    end
endmodule

// File: tb/tb_signal_despread.sv
// tb_signal_despread: directed scenario tasks with hand-computed symbol results
module tb_signal_despread;
  logic clk = 1'b0;
  logic rst, sync_start, sync_stop, sv, cv;
  logic signed [31:0] smp;
  logic signed [15:0] code;
  logic signed [31:0] corr_out;
  logic corr_valid, bit_out, corr_sat, sample_miss, busy;

  signal_despread dut (
    .clk(clk), .rst(rst), .sync_start(sync_start), .sync_stop(sync_stop),
    .Signal_Recv(smp), .Signal_Recv_valid(sv), .MSEQ_code(code), .MSEQ_code_valid(cv),
    .corr_out(corr_out), .corr_valid(corr_valid), .bit_out(bit_out), .corr_sat(corr_sat),
    .sample_miss(sample_miss), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; logic [31:0] v; logic b; logic s;} strobe_t;
  strobe_t q[$];
  always @(negedge clk) if (corr_valid === 1'b1) q.push_back('{cyc, corr_out, bit_out, corr_sat});

  int checks = 0, errors = 0, lp, lp1, fp;

  task automatic drive(input logic vs, input logic vc, input logic [31:0] s, input logic [15:0] c,
                       input logic st, input logic sp);
    sv = vs; cv = vc; smp = s; code = c; sync_start = st; sync_stop = sp;
    @(posedge clk); #1;
    sv = 0; cv = 0; sync_start = 0; sync_stop = 0;
  endtask

  task automatic pairs(input int n, input logic [31:0] s, input logic [15:0] c);
    repeat (n) drive(1, 1, s, c, 0, 0);
    lp = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    checks++; if ({corr_out, corr_valid, bit_out, corr_sat, sample_miss, busy} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {corr_out, corr_valid, bit_out, corr_sat, sample_miss, busy});
    end
    idle(3);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL reset_no_strobe got=%0d exp=0", q.size()); end
    q.delete();
  endtask

  task automatic test_basic;
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    pairs(64, 1000, 1);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].c != lp + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", q[0].c, lp + 1); end
      checks++; if (q[0].v !== 32'd1000) begin errors++; $display("FAIL basic_value got=%0d exp=1000", q[0].v); end
      checks++; if ({q[0].b, q[0].s} !== 2'b10) begin errors++; $display("FAIL basic_bit_sat got=%b exp=10", {q[0].b, q[0].s}); end
    end
    q.delete();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 128; i++) begin
      int c = i[0] ? -1024 : 1024;
      drive(1, 1, 32'(c * 3), 16'(c), 0, 0);
      if (i == 63) lp1 = cyc;
    end
    lp = cyc;
    idle(4);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", q.size()); end
    else begin
      checks++; if (q[0].c != lp1 + 1 || q[1].c != lp + 1) begin
        errors++; $display("FAIL b2b_timing got=%0d,%0d exp=%0d,%0d", q[0].c, q[1].c, lp1 + 1, lp + 1);
      end
      checks++; if (q[1].c - q[0].c != 64) begin errors++; $display("FAIL b2b_spacing got=%0d exp=64", q[1].c - q[0].c); end
      checks++; if (q[0].v !== 32'd3145728 || q[1].v !== 32'd3145728 || !q[0].b || !q[1].b) begin
        errors++; $display("FAIL b2b_value got=%0d,%0d exp=3145728", q[0].v, q[1].v);
      end
    end
    q.delete();
    for (int i = 0; i < 64; i++) begin
      int c = i[0] ? -1024 : 1024;
      drive(1, 1, 32'(-c * 3), 16'(c), 0, 0);
    end
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL inv_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].v !== 32'hFFD0_0000 || q[0].b !== 1'b0) begin
        errors++; $display("FAIL inv_value got=%h/%b exp=ffd00000/0", q[0].v, q[0].b);
      end
    end
    q.delete();
  endtask

  task automatic test_dropout;
    drive(1, 1, 1000, 1, 0, 0);
    fp = cyc;
    pairs(19, 1000, 1);
    repeat (5) drive(0, 1, 7777, 1, 0, 0);
    pairs(44, 1000, 1);
    idle(4);
    checks++; if (lp - fp != 68 || q.size() != 1) begin errors++; $display("FAIL gap_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].c != fp + 69 || q[0].v !== 32'd1000) begin
        errors++; $display("FAIL gap_strobe got=%0d/%0d exp=%0d/1000", q[0].c, q[0].v, fp + 69);
      end
    end
    q.delete();
    checks++; if (sample_miss !== 1'b0) begin errors++; $display("FAIL miss_clear_before got=%b exp=0", sample_miss); end
    pairs(10, 1000, 1);
    drive(1, 0, 5000, 0, 0, 0);
    checks++; if (sample_miss !== 1'b1) begin errors++; $display("FAIL miss_set got=%b exp=1", sample_miss); end
    pairs(54, 1000, 1);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL miss_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].c != lp + 1 || q[0].v !== 32'd1000) begin
        errors++; $display("FAIL miss_strobe got=%0d/%0d exp=%0d/1000", q[0].c, q[0].v, lp + 1);
      end
    end
    q.delete();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (sample_miss !== 1'b0) begin errors++; $display("FAIL miss_cleared got=%b exp=0", sample_miss); end
  endtask

  task automatic test_restart;
    pairs(30, 1000, 1);
    drive(0, 0, 0, 0, 1, 0);
    pairs(64, 2000, 1);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL restart_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].c != lp + 1 || q[0].v !== 32'd2000) begin
        errors++; $display("FAIL restart_strobe got=%0d/%0d exp=%0d/2000", q[0].c, q[0].v, lp + 1);
      end
    end
    q.delete();
    pairs(10, 1000, 1);
    drive(1, 1, 3000, 1, 1, 0);
    pairs(63, 3000, 1);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL chip0_count got=%0d exp=1", q.size()); end
    else begin
      checks++; if (q[0].c != lp + 1 || q[0].v !== 32'd3000) begin
        errors++; $display("FAIL chip0_strobe got=%0d/%0d exp=%0d/3000", q[0].c, q[0].v, lp + 1);
      end
    end
    q.delete();
    pairs(5, 1000, 1);
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
    pairs(64, 1000, 1);
    idle(4);
    checks++; if (q.size() != 0 || corr_out !== 32'd3000) begin
      errors++; $display("FAIL stop_idle got=%0d/%0d exp=0/3000", q.size(), corr_out);
    end
    q.delete();
  endtask

  task automatic test_sat;
    drive(0, 0, 0, 0, 1, 0);
    pairs(64, 32'h7FFF_FFFF, 16'd32767);
    idle(4);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL sat_count got=%0d exp=1", q.size()); end
    else begin
`ifdef SIGNAL_DESPREAD_SAT_EN
      checks++; if (q[0].v !== 32'h7FFF_FFFF || q[0].s !== 1'b1) begin
        errors++; $display("FAIL sat_value got=%h/%b exp=7fffffff/1", q[0].v, q[0].s);
      end
`else
      checks++; if (q[0].v !== 32'h7FFF_8001 || q[0].s !== 1'b0) begin
        errors++; $display("FAIL wrap_value got=%h/%b exp=7fff8001/0", q[0].v, q[0].s);
      end
`endif
      checks++; if (q[0].b !== 1'b1) begin errors++; $display("FAIL sat_bit got=%b exp=1", q[0].b); end
    end
    q.delete();
  endtask

  task automatic test_async_reset;
    pairs(20, 1000, 1);
    drive(1, 0, 1000, 0, 0, 0);
    #3 rst = 1;
    #1;
    checks++; if ({corr_out, corr_valid, bit_out, corr_sat, sample_miss, busy} !== 37'd0) begin
      errors++; $display("FAIL async_reset got=%h exp=0", {corr_out, corr_valid, bit_out, corr_sat, sample_miss, busy});
    end
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    pairs(64, 1000, 1);
    idle(4);
    checks++; if (q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got=%0d/%b exp=0/0", q.size(), busy);
    end
    q.delete();
    drive(0, 0, 0, 0, 1, 0);
    pairs(64, 1000, 1);
    idle(4);
    checks++; if (q.size() != 1 || q[0].v !== 32'd1000) begin
      errors++; $display("FAIL post_reset_symbol got=%0d exp=1", q.size());
    end
    q.delete();
  endtask

  initial begin
    rst = 1; sync_start = 0; sync_stop = 0; sv = 0; cv = 0; smp = 0; code = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_dropout;
    test_restart;
    test_sat;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/signal_despread.md
Name: signal_despread

Overview:
Receive-side counterpart of the transmit chain's Signal_Modulation stage. Takes the modulated 32-bit sample stream and a locally regenerated, already-aligned M-sequence code stream. Multiplies each sample by its code value, integrates over a symbol of SYMBOL_LEN chips, and emits one scaled correlation value plus a hard bit decision per symbol. Sits between the receive sample source and the downstream DDS-reference demodulation and bit sink.

Parameters:
SAMPLE_WIDTH, 32, signed width of received sample.
CODE_WIDTH, 16, signed width of local M-sequence code value.
SYMBOL_LEN, 64, accepted sample/code pairs per symbol (power of two, ≥2).
ACC_WIDTH, 56, signed accumulator width; must be ≥ SAMPLE_WIDTH+CODE_WIDTH+log2(SYMBOL_LEN).
OUT_SHIFT, 6, arithmetic right shift applied to the accumulator before output.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
sync_start  in  1  one-cycle pulse; (re)starts symbol integration at chip 0.
sync_stop  in  1  one-cycle pulse; returns the block to IDLE.
Signal_Recv  in  SAMPLE_WIDTH  signed received sample.
Signal_Recv_valid  in  1  sample qualifier.
MSEQ_code  in  CODE_WIDTH  signed local code value for the current chip.
MSEQ_code_valid  in  1  code qualifier.
corr_out  out  32  signed (acc >>> OUT_SHIFT), resized to 32 bits.
corr_valid  out  1  one-cycle strobe qualifying corr_out and bit_out.
bit_out  out  1  hard decision: 1 when the full accumulator is ≥ 0, else 0.
corr_sat  out  1  corr_out was clamped this symbol (see Optional Feature).
sample_miss  out  1  sticky: a sample arrived without a code value.
busy  out  1  high in ACCUM.

Behaviour:
- Reset (asynchronous assert, released on clk): state IDLE; chip counter 0; accumulator 0; pipeline valid flags 0. corr_out=0, corr_valid=0, bit_out=0, corr_sat=0, sample_miss=0, busy=0.
- States:
  - IDLE: all inputs except sync_start are ignored. sync_start→ACCUM.
  - ACCUM: sync_stop→IDLE. sync_start→ACCUM with restart. Otherwise stay.
  - sync_stop and sync_start in the same cycle: sync_stop wins.
- Pair acceptance (ACCUM only): a pair is accepted when Signal_Recv_valid & MSEQ_code_valid are high in the same cycle.
  - Signal_Recv_valid alone: sample dropped, counter not advanced, sample_miss set.
  - MSEQ_code_valid alone: ignored.
- Pipeline:
  - Stage 1: register product = Signal_Recv × MSEQ_code, full signed SAMPLE_WIDTH+CODE_WIDTH bits.
  - Stage 2: accumulate. For the first chip of a symbol, acc ← product (no bubble between symbols). Otherwise acc ← acc + product, sign-extended to ACC_WIDTH.
- Chip counter: increments on each accepted pair and wraps from SYMBOL_LEN-1 to 0. The pair accepted at count SYMBOL_LEN-1 is the last chip of the symbol.
- Output timing: if the last chip is accepted in cycle t, corr_valid is high in cycle t+2. corr_out, bit_out and corr_sat update in the same cycle and hold until the next strobe. Back-to-back symbols at full rate give one strobe every SYMBOL_LEN cycles.
- Restart (sync_start while in ACCUM):
  - counter ← 0; the partial symbol is discarded with no strobe for it.
  - Stage-1/2 contents in flight are flushed; a strobe already due from a completed symbol still fires.
  - sample_miss is cleared.
  - A pair accepted in the same cycle as sync_start counts as chip 0 of the new symbol.
- sync_stop: counter 0, in-flight data flushed, no pending strobe, outputs hold their last values, busy=0.
- Width rule: corr_out is taken from (acc >>> OUT_SHIFT). Handling of values outside the 32-bit range is given by the Optional Feature.

Optional Feature:
- Macro SIGNAL_DESPREAD_SAT_EN.
- Defined: a shifted value above 2^31−1 or below −2^31 is clamped to that bound and corr_sat=1 for that symbol; otherwise corr_sat=0.
- Undefined: corr_out keeps the low 32 bits (two's-complement wrap) and corr_sat is tied 0.
- bit_out always uses the full accumulator sign, independent of the macro.

Decomposition:
- Package despread_pkg: state enum (IDLE, ACCUM), default width constants, a CNT_WIDTH=$clog2(SYMBOL_LEN) helper, and the 32-bit saturation bounds.
- Sub-module despread_mac: the two-stage multiply-accumulate with first-chip load, flush input and done output.
- Top level holds the FSM, chip counter, the miss flag and the output shift/saturation.

Test Plan:
1. Reset, then sync_start; 64 pairs with sample=1000 and code=+1 every cycle → one corr_valid 2 cycles after the 64th pair, corr_out=1000, bit_out=1, corr_sat=0.
2. Alternating code ±1024 with sample = code×3, 128 pairs back-to-back → two strobes 64 cycles apart, each corr_out=3145728, bit_out=1. Invert all samples → corr_out=−3145728, bit_out=0.
3. Sample valid drops out for 5 cycles mid-symbol, code still valid → strobe is delayed by 5 cycles and the value is unchanged. Sample valid without code valid once → sample_miss=1 and the pair is not counted; the next sync_start clears it.
4. sync_start after 30 accepted pairs → no strobe for the partial symbol; a strobe follows 64 pairs after the restart. sync_stop with sync_start in the same cycle → IDLE, busy=0.
5. Sample=2^31−1, code=32767, 64 pairs → macro defined: corr_out=0x7FFFFFFF, corr_sat=1. Macro undefined: corr_out = low 32 bits of the true value, corr_sat=0. bit_out=1 in both builds.
6. rst asserted between clk edges mid-symbol → all outputs 0 immediately. After release, inputs are ignored until sync_start.
